// File: rtl/anim_frame_sequencer_if.sv
// Control/status bundle for anim_frame_sequencer.
//   frame_start : one-cycle strobe at the first pixel of each video frame
//   enable      : 1 = count strobes, 0 = freeze
//   mode        : 00 loop-up, 01 ping-pong, 10 one-shot, 11 loop-down
//   hold_frames : video frames per animation step (0 behaves as 1)
//   restart     : synchronous restart request
//   frame_num   : current animation frame index
//   step        : pulse in the cycle frame_num takes a new step value
//   dir         : ping-pong direction (0 up, 1 down)
//   done        : sticky one-shot completion flag
// master drives the controls, slave is the sequencer.
interface anim_frame_sequencer_if #(
    parameter int unsigned FRAME_W = 2,
    parameter int unsigned HOLD_W  = 6
);
    logic               frame_start;
    logic               enable;
    logic [1:0]         mode;
    logic [HOLD_W-1:0]  hold_frames;
    logic               restart;
    logic [FRAME_W-1:0] frame_num;
    logic               step;
    logic               dir;
    logic               done;

    modport master (
        output frame_start, enable, mode, hold_frames, restart,
        input  frame_num, step, dir, done
    );

    modport slave (
        input  frame_start, enable, mode, hold_frames, restart,
        output frame_num, step, dir, done
    );
endinterface

// File: rtl/anim_frame_sequencer.sv
// Animation frame sequencer: counts qualified frame_start strobes, and every
// hold_frames of them advances frame_num according to the selected mode
// (loop-up, ping-pong, one-shot, loop-down). All outputs are registered.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : anim_frame_sequencer_if.slave (controls in, frame_num/step/dir/done out)
module anim_frame_sequencer #(
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned FRAME_W    = 2,
    parameter int unsigned HOLD_W     = 6
) (
    input logic                    clk,
    input logic                    rst_n,
    anim_frame_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ModeLoopUp   = 2'b00,
        ModePingPong = 2'b01,
        ModeOneShot  = 2'b10,
        ModeLoopDown = 2'b11
    } mode_e;

    localparam logic [FRAME_W-1:0] LastFrame   = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FrameOne    = FRAME_W'(1);
    localparam logic [HOLD_W-1:0]  HoldOne     = HOLD_W'(1);
    localparam bit                 SingleFrame = (NUM_FRAMES == 1);

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;

    logic [HOLD_W-1:0]  hold_eff;
    logic [HOLD_W-1:0]  hold_last;
    logic               qual;
    mode_e              mode;

    always_comb begin
        hold_eff   = (bus.hold_frames == '0) ? HoldOne : bus.hold_frames;
        hold_last  = hold_eff - HoldOne;
        qual       = bus.frame_start & bus.enable & ~bus.restart;
        mode       = mode_e'(bus.mode);

        frame_d    = frame_q;
        hold_cnt_d = hold_cnt_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        done_d     = done_q;

        if (bus.restart) begin
            frame_d    = '0;
            hold_cnt_d = '0;
            dir_d      = 1'b0;
            done_d     = 1'b0;
        end else begin
            if (mode != ModeOneShot) begin
                done_d = 1'b0;
            end
            // A finished one-shot freezes the hold counter as well as the frame.
            if (qual && !(mode == ModeOneShot && done_q)) begin
                // >= (not ==) so shrinking hold_frames mid-count advances at once.
                if (hold_cnt_q >= hold_last) begin
                    hold_cnt_d = '0;
                    step_d     = 1'b1;
                    unique case (mode)
                        ModeLoopUp: begin
                            frame_d = (frame_q == LastFrame) ? '0 : frame_q + FrameOne;
                        end
                        ModeLoopDown: begin
                            frame_d = (frame_q == '0) ? LastFrame : frame_q - FrameOne;
                        end
                        ModePingPong: begin
                            if (SingleFrame) begin
                                frame_d = frame_q;
                            end else if (!dir_q) begin
                                // Turn around at the top without repeating the end frame.
                                if (frame_q == LastFrame) begin
                                    dir_d   = 1'b1;
                                    frame_d = frame_q - FrameOne;
                                end else begin
                                    frame_d = frame_q + FrameOne;
                                end
                            end else begin
                                if (frame_q == '0) begin
                                    dir_d   = 1'b0;
                                    frame_d = frame_q + FrameOne;
                                end else begin
                                    frame_d = frame_q - FrameOne;
                                end
                            end
                        end
                        ModeOneShot: begin
                            if (frame_q == LastFrame) begin
                                done_d = 1'b1;
                            end else begin
                                frame_d = frame_q + FrameOne;
                                done_d  = (frame_q + FrameOne == LastFrame);
                            end
                        end
                        default: begin
                            frame_d = frame_q;
                        end
                    endcase
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldOne;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= '0;
            hold_cnt_q <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            hold_cnt_q <= hold_cnt_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
        end
    end

    assign bus.frame_num = frame_q;
    assign bus.step      = step_q;
    assign bus.dir       = dir_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed bench for anim_frame_sequencer. Three instances (N=4, N=3, N=1) share
// one set of control inputs; a vector table covers the modes, then hand-written
// sequences cover hold shrink, restart collisions and asynchronous reset.
module tb_anim_frame_sequencer;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       enable;
    logic [1:0] mode;
    logic [5:0] hold_frames;
    logic       restart;

    int checks;
    int errors;

    anim_frame_sequencer_if #(.FRAME_W(2), .HOLD_W(6)) if4 ();
    anim_frame_sequencer_if #(.FRAME_W(2), .HOLD_W(6)) if3 ();
    anim_frame_sequencer_if #(.FRAME_W(1), .HOLD_W(6)) if1 ();

    assign if4.frame_start = frame_start;
    assign if4.enable      = enable;
    assign if4.mode        = mode;
    assign if4.hold_frames = hold_frames;
    assign if4.restart     = restart;
    assign if3.frame_start = frame_start;
    assign if3.enable      = enable;
    assign if3.mode        = mode;
    assign if3.hold_frames = hold_frames;
    assign if3.restart     = restart;
    assign if1.frame_start = frame_start;
    assign if1.enable      = enable;
    assign if1.mode        = mode;
    assign if1.hold_frames = hold_frames;
    assign if1.restart     = restart;

    anim_frame_sequencer #(.NUM_FRAMES(4), .FRAME_W(2), .HOLD_W(6)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );
    anim_frame_sequencer #(.NUM_FRAMES(3), .FRAME_W(2), .HOLD_W(6)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );
    anim_frame_sequencer #(.NUM_FRAMES(1), .FRAME_W(1), .HOLD_W(6)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fs;
        logic       rs;
        logic       en;
        logic [1:0] md;
        logic [5:0] hold;
        int         f4;
        logic       s4;
        logic       d4;
        int         f3;
        logic       dn3;
        int         f1;
        logic       s1;
        logic       dn1;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic fs, input logic rs, input logic en,
                                input logic [1:0] md, input logic [5:0] hold,
                                input int f4, input logic s4, input logic d4,
                                input int f3, input logic dn3,
                                input int f1, input logic s1, input logic dn1);
        vec_t v;
        v.fs = fs; v.rs = rs; v.en = en; v.md = md; v.hold = hold;
        v.f4 = f4; v.s4 = s4; v.d4 = d4;
        v.f3 = f3; v.dn3 = dn3;
        v.f1 = f1; v.s1 = s1; v.dn1 = dn1;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive strobe/restart for exactly one edge, return 1ns after it.
    task automatic tick(input logic fs, input logic rs);
        @(negedge clk);
        frame_start = fs;
        restart     = rs;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        restart     = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        enable      = 1'b1;
        mode        = 2'b00;
        hold_frames = 6'd3;
        restart     = 1'b0;

        // fs rs en md hold | f4 s4 d4 | f3 dn3 | f1 s1 dn1
        // Loop-up, hold 3, 13 strobes.
        add(1, 0, 1, 2'b00, 3,  0, 0, 0,  0, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  0, 0, 0,  0, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  1, 1, 0,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b00, 3,  1, 0, 0,  1, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  1, 0, 0,  1, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  2, 1, 0,  2, 0,  0, 1, 0);
        add(1, 0, 1, 2'b00, 3,  2, 0, 0,  2, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  2, 0, 0,  2, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  3, 1, 0,  0, 0,  0, 1, 0);
        add(1, 0, 1, 2'b00, 3,  3, 0, 0,  0, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  3, 0, 0,  0, 0,  0, 0, 0);
        add(1, 0, 1, 2'b00, 3,  0, 1, 0,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b00, 3,  0, 0, 0,  1, 0,  0, 0, 0);
        // Restart wins over a simultaneous strobe.
        add(1, 1, 1, 2'b00, 3,  0, 0, 0,  0, 0,  0, 0, 0);
        // Ping-pong, hold 0, 10 strobes.
        add(1, 0, 1, 2'b01, 0,  1, 1, 0,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  2, 1, 0,  2, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  3, 1, 0,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  2, 1, 1,  0, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  1, 1, 1,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  0, 1, 1,  2, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  1, 1, 0,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  2, 1, 0,  0, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  3, 1, 0,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b01, 0,  2, 1, 1,  2, 0,  0, 1, 0);
        // Strobe ignored while disabled; mode change alone changes nothing.
        add(1, 0, 0, 2'b01, 0,  2, 0, 1,  2, 0,  0, 0, 0);
        add(0, 0, 1, 2'b11, 0,  2, 0, 1,  2, 0,  0, 0, 0);
        // Loop-down; dir keeps its ping-pong value.
        add(1, 0, 1, 2'b11, 0,  1, 1, 1,  1, 0,  0, 1, 0);
        add(1, 0, 1, 2'b11, 0,  0, 1, 1,  0, 0,  0, 1, 0);
        add(1, 0, 1, 2'b11, 0,  3, 1, 1,  2, 0,  0, 1, 0);
        add(0, 1, 1, 2'b11, 0,  0, 0, 0,  0, 0,  0, 0, 0);
        // One-shot, hold 1, 5 strobes, then restart.
        add(1, 0, 1, 2'b10, 1,  1, 1, 0,  1, 0,  0, 1, 1);
        add(1, 0, 1, 2'b10, 1,  2, 1, 0,  2, 1,  0, 0, 1);
        add(1, 0, 1, 2'b10, 1,  3, 1, 0,  2, 1,  0, 0, 1);
        add(1, 0, 1, 2'b10, 1,  3, 0, 0,  2, 1,  0, 0, 1);
        add(1, 0, 1, 2'b10, 1,  3, 0, 0,  2, 1,  0, 0, 1);
        add(0, 1, 1, 2'b10, 1,  0, 0, 0,  0, 0,  0, 0, 0);
        // done clears when mode leaves one-shot.
        add(1, 0, 1, 2'b10, 0,  1, 1, 0,  1, 0,  0, 1, 1);
        add(0, 0, 1, 2'b00, 0,  1, 0, 0,  1, 0,  0, 0, 0);

        #3;
        chk("reset f4", if4.frame_num, 0);
        chk("reset s4", if4.step, 0);
        chk("reset d4", if4.dir, 0);
        chk("reset dn3", if3.done, 0);
        chk("reset f1", if1.frame_num, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post-reset s4", if4.step, 0);
        chk("post-reset f4", if4.frame_num, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            enable      = vecs[i].en;
            mode        = vecs[i].md;
            hold_frames = vecs[i].hold;
            tick(vecs[i].fs, vecs[i].rs);
            chk($sformatf("vec%0d f4", i), if4.frame_num, vecs[i].f4);
            chk($sformatf("vec%0d s4", i), if4.step, vecs[i].s4);
            chk($sformatf("vec%0d d4", i), if4.dir, vecs[i].d4);
            chk($sformatf("vec%0d f3", i), if3.frame_num, vecs[i].f3);
            chk($sformatf("vec%0d dn3", i), if3.done, vecs[i].dn3);
            chk($sformatf("vec%0d f1", i), if1.frame_num, vecs[i].f1);
            chk($sformatf("vec%0d s1", i), if1.step, vecs[i].s1);
            chk($sformatf("vec%0d dn1", i), if1.done, vecs[i].dn1);
            chk($sformatf("vec%0d d1", i), if1.dir, 0);
        end

        // Shrinking hold_frames mid-count advances on the next strobe.
        enable = 1'b1;
        mode = 2'b00;
        hold_frames = 6'd10;
        tick(0, 1);
        repeat (7) tick(1, 0);
        chk("shrink pre f4", if4.frame_num, 0);
        hold_frames = 6'd4;
        tick(1, 0);
        chk("shrink adv f4", if4.frame_num, 1);
        chk("shrink adv s4", if4.step, 1);
        repeat (3) tick(1, 0);
        chk("shrink hold f4", if4.frame_num, 1);
        chk("shrink hold s4", if4.step, 0);
        tick(1, 0);
        chk("shrink next f4", if4.frame_num, 2);

        // Restart colliding with an advancing strobe.
        hold_frames = 6'd3;
        tick(0, 1);
        repeat (3) tick(1, 0);
        chk("coll pre f4", if4.frame_num, 1);
        repeat (2) tick(1, 0);
        tick(1, 1);
        chk("coll f4", if4.frame_num, 0);
        chk("coll s4", if4.step, 0);
        repeat (2) tick(1, 0);
        chk("coll hold s4", if4.step, 0);
        tick(1, 0);
        chk("coll adv f4", if4.frame_num, 1);
        chk("coll adv s4", if4.step, 1);
        enable = 1'b0;
        repeat (3) tick(1, 0);
        chk("dis f4", if4.frame_num, 1);
        chk("dis s4", if4.step, 0);
        tick(0, 1);
        chk("dis restart f4", if4.frame_num, 0);

        // Asynchronous reset mid-sequence while step is high.
        enable = 1'b1;
        hold_frames = 6'd0;
        repeat (2) tick(1, 0);
        chk("arst pre f4", if4.frame_num, 2);
        chk("arst pre s4", if4.step, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst f4", if4.frame_num, 0);
        chk("arst s4", if4.step, 0);
        chk("arst f3", if3.frame_num, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_frames = 6'd3;
        tick(0, 0);
        chk("arst rel s4", if4.step, 0);
        repeat (2) tick(1, 0);
        chk("arst hold s4", if4.step, 0);
        chk("arst hold f4", if4.frame_num, 0);
        tick(1, 0);
        chk("arst adv s4", if4.step, 1);
        chk("arst adv f4", if4.frame_num, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/anim_frame_sequencer.md
ANIM_FRAME_SEQUENCER -- requirements
Module: anim_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 4, number of animation frames (legal 1..256).
REQ-002 SHALL have parameter FRAME_W, default 2, width of frame_num (equal to max(1, clog2(NUM_FRAMES))).
REQ-003 SHALL have parameter HOLD_W, default 6, width of hold_frames and the internal hold counter.
REQ-004 clk  input  1  sole clock; one clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 frame_start  input  1  one-cycle strobe at the first pixel of each video frame.
REQ-007 enable  input  1  1 = count frame_start strobes; 0 = freeze all state.
REQ-008 mode  input  2  00 loop-up, 01 ping-pong, 10 one-shot, 11 loop-down.
REQ-009 hold_frames  input  HOLD_W  video frames per animation step; 0 is treated as 1.
REQ-010 restart  input  1  synchronous one-cycle restart request.
REQ-011 frame_num  output  FRAME_W  current animation frame index, registered.
REQ-012 step  output  1  one-cycle pulse, high in the cycle frame_num takes a new step value.
REQ-013 dir  output  1  current ping-pong direction (0 up, 1 down), registered.
REQ-014 done  output  1  sticky one-shot completion flag, registered.

Function
REQ-015 Internal hold_cnt (HOLD_W bits); hold_eff = (hold_frames == 0) ? 1 : hold_frames.
REQ-016 Qualified strobe q = frame_start & enable & ~restart; no state changes when q = 0, except on restart.
REQ-017 On q: if hold_cnt >= hold_eff-1, clear hold_cnt and perform an advance; else increment hold_cnt.
REQ-018 The >= compare SHALL make a mid-count decrease of hold_frames advance on the next q, never after a wrap.
REQ-019 Latency: frame_num and step SHALL update on the clock edge that samples the advancing q (one-cycle latency).
REQ-020 step SHALL pulse on every advance, including advances that leave frame_num unchanged (NUM_FRAMES = 1, ping-pong turn-around excluded: see REQ-023).
REQ-021 Loop-up: frame_num = frame_num+1; at NUM_FRAMES-1 wraps to 0.
REQ-022 Loop-down: frame_num = frame_num-1; at 0 wraps to NUM_FRAMES-1.
REQ-023 Ping-pong: moves in direction dir; at an end (NUM_FRAMES-1 going up, 0 going down) dir flips and frame_num moves one step the other way in the same advance (no repeated end frame; sequence for N=4: 0,1,2,3,2,1,0,1...).
REQ-024 Ping-pong, NUM_FRAMES = 1: frame_num stays 0, dir stays 0, step still pulses.
REQ-025 One-shot: increments until NUM_FRAMES-1; the advance that reaches NUM_FRAMES-1 sets done in the same edge.
REQ-026 One-shot with done = 1: further advances leave frame_num and hold_cnt frozen and produce no step.
REQ-027 One-shot with NUM_FRAMES = 1: the first advance sets done and pulses step.
REQ-028 dir SHALL change only in ping-pong mode; other modes hold dir at its last value.
REQ-029 Mode change takes effect at the next advance; frame_num, hold_cnt, dir are not modified by the change itself.
REQ-030 done SHALL clear only on restart, or when mode leaves one-shot (cleared on the next clock edge).
REQ-031 restart: next edge sets frame_num=0, hold_cnt=0, dir=0, done=0, step=0; takes priority over a simultaneous frame_start.
REQ-032 restart SHALL act regardless of enable.
REQ-033 All arithmetic SHALL wrap at parameter bounds, not at FRAME_W power-of-two bounds (e.g., NUM_FRAMES=3, FRAME_W=2 never outputs 3).

Reset
REQ-034 While rst_n = 0: frame_num=0, hold_cnt=0, dir=0, done=0, step=0, asynchronously.
REQ-035 Reset deassertion SHALL not generate step; first advance needs hold_eff qualified strobes.
REQ-036 Reset asserted mid-hold or mid-sequence SHALL discard all progress with no residual pulse.

Verification
REQ-037 N=4, mode 00, hold_frames=3, enable=1, 13 strobes -> frame_num 0,1,2,3,0 after strobes 0,3,6,9,12; step pulses exactly 4 times.
REQ-038 N=4, mode 01, hold_frames=0, 8 strobes -> frame_num 1,2,3,2,1,0,1,2; dir 1 from the 3rd-to-4th advance until frame 0.
REQ-039 N=3, FRAME_W=2, mode 10, hold_frames=1, 5 strobes -> frame_num 1,2,2,2,2; done=1 after strobe 2; steps=2; restart -> frame_num=0, done=0.
REQ-040 hold_frames=10, hold_cnt reaches 7, hold_frames changed to 4 -> advance on the very next strobe, hold_cnt=0.
REQ-041 restart and frame_start same cycle at hold_cnt=hold_eff-1 -> frame_num=0, no step; enable=0 strobes -> no change.
REQ-042 rst_n pulsed low mid-sequence (frame 2, done=0) -> all outputs 0 immediately, no step after release.
